// File: rtl/mru_arb.sv
// N-port memory request unit: round-robin arbitration of CPU-side requestors
// onto a single Wishbone classic master, with alignment, bus-error and timeout reporting.
module mru_arb #(
  parameter int NPORTS  = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NPORTS-1:0]                    req_en,
  input  logic [NPORTS*ADDR_W-1:0]             req_addr,
  input  logic [NPORTS-1:0]                    req_we,
  input  logic [NPORTS*2-1:0]                  req_size,
  input  logic [NPORTS*DATA_W-1:0]             req_wdata,
  output logic [NPORTS-1:0]                    req_stl,
  output logic [NPORTS-1:0]                    req_ack,
  output logic [NPORTS-1:0]                    req_err,
  output logic [DATA_W-1:0]                    req_rdata,
  input  logic [DATA_W-1:0]                    dat_i,
  input  logic                                 ack_i,
  input  logic                                 err_i,
  output logic [DATA_W-1:0]                    dat_o,
  output logic [ADDR_W-$clog2(DATA_W/8)-1:0]   adr_o,
  output logic                                 cyc_o,
  output logic                                 stb_o,
  output logic                                 we_o,
  output logic [DATA_W/8-1:0]                  sel_o
);

  localparam int LANES = DATA_W / 8;
  localparam int OFF   = $clog2(LANES);
  localparam int PTR_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                 state;
  logic [PTR_W-1:0]       rr_ptr;
  logic [PTR_W-1:0]       gnt;
  logic [OFF-1:0]         lat_off;
  logic [1:0]             lat_size;
  logic                   resp_err;
  logic [CNT_W-1:0]       cnt;
  logic                   cyc_q;

  logic [PTR_W-1:0]       gnt_next;
  logic                   found;
  int                     idx;
  logic [ADDR_W-1:0]      s_addr;
  logic [1:0]             s_size;
  logic                   s_we;
  logic [DATA_W-1:0]      s_wdata;
  logic [OFF-1:0]         s_off;
  logic                   s_bad;
  logic                   timeout_hit;
  logic [NPORTS-1:0]      gnt_oh;
  logic [NPORTS-1:0]      resp_vec;
  logic [DATA_W-1:0]      rd_shifted;

  function automatic logic misaligned(input logic [ADDR_W-1:0] addr, input logic [1:0] size);
    logic bad;
    bad = 1'b0;
    case (size)
      2'd0:    bad = 1'b0;
      2'd1:    bad = addr[0];
      2'd2:    bad = |addr[1:0];
      default: bad = (DATA_W == 32) || (|addr[2:0]);
    endcase
    return bad;
  endfunction

  function automatic logic [LANES-1:0] lane_sel(input logic [1:0] size, input logic [OFF-1:0] off);
    logic [15:0] m;
    case (size)
      2'd0:    m = 16'h0001;
      2'd1:    m = 16'h0003;
      2'd2:    m = 16'h000F;
      default: m = 16'h00FF;
    endcase
    m = m << off;
    return m[LANES-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] size_mask(input logic [1:0] size);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int b = 0; b < LANES; b++) begin
      if (b < (1 << size)) m[b*8 +: 8] = 8'hFF;
    end
    return m;
  endfunction

  // Round-robin search: first requesting port at or after rr_ptr, wrapping.
  always_comb begin
    gnt_next = rr_ptr;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < NPORTS; i++) begin
      idx = (int'(rr_ptr) + i) % NPORTS;
      if (!found && req_en[idx]) begin
        found    = 1'b1;
        gnt_next = PTR_W'(idx);
      end
    end
  end

  assign s_addr  = req_addr[gnt_next*ADDR_W +: ADDR_W];
  assign s_size  = req_size[gnt_next*2 +: 2];
  assign s_we    = req_we[gnt_next];
  assign s_wdata = req_wdata[gnt_next*DATA_W +: DATA_W];
  assign s_off   = s_addr[OFF-1:0];
  assign s_bad   = misaligned(s_addr, s_size);

  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
  assign rd_shifted  = dat_i >> {lat_off, 3'b000};

  assign gnt_oh   = NPORTS'(1) << gnt;
  assign resp_vec = (state == RESP) ? gnt_oh : '0;
  assign req_stl  = req_en & ~resp_vec;
  assign req_ack  = resp_vec & req_en & {NPORTS{~resp_err}};
  assign req_err  = resp_vec & req_en & {NPORTS{resp_err}};

  assign cyc_o = cyc_q;
  assign stb_o = cyc_q;

  // Bus-side outputs are loaded at grant and cleared as the FSM leaves BUS,
  // so the Wishbone strobe drops on a clock edge rather than combinationally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt       <= '0;
      lat_off   <= '0;
      lat_size  <= '0;
      resp_err  <= 1'b0;
      cnt       <= '0;
      cyc_q     <= 1'b0;
      adr_o     <= '0;
      we_o      <= 1'b0;
      sel_o     <= '0;
      dat_o     <= '0;
      req_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_en) begin
            gnt      <= gnt_next;
            rr_ptr   <= PTR_W'((int'(gnt_next) + 1) % NPORTS);
            lat_off  <= s_off;
            lat_size <= s_size;
            if (s_bad) begin
              resp_err <= 1'b1;
              state    <= RESP;
            end else begin
              resp_err <= 1'b0;
              state    <= BUS;
              cnt      <= '0;
              cyc_q    <= 1'b1;
              adr_o    <= s_addr[ADDR_W-1:OFF];
              we_o     <= s_we;
              sel_o    <= lane_sel(s_size, s_off);
              dat_o    <= s_wdata << {s_off, 3'b000};
            end
          end
        end
        BUS: begin
          if (err_i || ack_i || timeout_hit) begin
            state    <= RESP;
            cyc_q    <= 1'b0;
            adr_o    <= '0;
            we_o     <= 1'b0;
            sel_o    <= '0;
            dat_o    <= '0;
            resp_err <= err_i || !ack_i;
            if (ack_i && !err_i) req_rdata <= rd_shifted & size_mask(lat_size);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mru_arb.sv
// Directed self-checking bench for mru_arb: two ports, 32-bit data, 16-cycle timeout,
// with a negedge-driven Wishbone slave model.
module tb_mru_arb;

  logic        clk;
  logic        rst;
  logic [1:0]  req_en;
  logic [63:0] req_addr;
  logic [1:0]  req_we;
  logic [3:0]  req_size;
  logic [63:0] req_wdata;
  logic [1:0]  req_stl;
  logic [1:0]  req_ack;
  logic [1:0]  req_err;
  logic [31:0] req_rdata;
  logic [31:0] dat_i;
  logic        ack_i;
  logic        err_i;
  logic [31:0] dat_o;
  logic [29:0] adr_o;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic [3:0]  sel_o;

  int          num_checks;
  int          num_passed;
  int          slave_mode;
  int          slave_waits;
  int          wcnt;
  logic [31:0] slave_data;
  int          lat;
  int          cyc_cnt;
  int          n_acks;
  int          last_ack;

  mru_arb #(
    .NPORTS(2),
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT(16)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .req_en(req_en),
    .req_addr(req_addr),
    .req_we(req_we),
    .req_size(req_size),
    .req_wdata(req_wdata),
    .req_stl(req_stl),
    .req_ack(req_ack),
    .req_err(req_err),
    .req_rdata(req_rdata),
    .dat_i(dat_i),
    .ack_i(ack_i),
    .err_i(err_i),
    .dat_o(dat_o),
    .adr_o(adr_o),
    .cyc_o(cyc_o),
    .stb_o(stb_o),
    .we_o(we_o),
    .sel_o(sel_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dat_i = slave_data;

  // Slave model: mode 0 acks after slave_waits cycles, mode 1 never answers,
  // mode 2 raises ack and err together in the first cycle.
  always @(negedge clk) begin
    if (cyc_o && stb_o) begin
      case (slave_mode)
        0: begin
          ack_i = (wcnt == slave_waits);
          err_i = 1'b0;
        end
        2: begin
          ack_i = 1'b1;
          err_i = 1'b1;
        end
        default: begin
          ack_i = 1'b0;
          err_i = 1'b0;
        end
      endcase
      wcnt = wcnt + 1;
    end else begin
      ack_i = 1'b0;
      err_i = 1'b0;
      wcnt  = 0;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    num_checks++;
    if (actual === expected) num_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  task automatic applyStimulus(input int p, input logic we, input logic [1:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata);
    req_en[p]             = 1'b1;
    req_we[p]             = we;
    req_size[p*2 +: 2]    = size;
    req_addr[p*32 +: 32]  = addr;
    req_wdata[p*32 +: 32] = wdata;
  endtask

  // Waits (bounded) for an ack or err pulse, counting cycles and strobe cycles seen.
  task automatic waitResp(input int limit, output int l, output int c);
    l = 0;
    c = 0;
    while (l < limit && (req_ack | req_err) == 2'b00) begin
      @(negedge clk);
      l++;
      if (cyc_o) c++;
    end
    if ((req_ack | req_err) == 2'b00) checkOutput("resp_wait", 64'd0, 64'd1);
  endtask

  initial begin
    num_checks  = 0;
    num_passed  = 0;
    slave_mode  = 0;
    slave_waits = 0;
    slave_data  = '0;
    wcnt        = 0;
    ack_i       = 1'b0;
    err_i       = 1'b0;
    rst         = 1'b1;
    req_en      = 2'b10;
    req_addr    = '0;
    req_we      = '0;
    req_size    = '0;
    req_wdata   = '0;

    repeat (2) @(negedge clk);
    checkOutput("reset_stl", 64'(req_stl), 64'h2);
    checkOutput("reset_cyc", 64'({cyc_o, stb_o}), 64'h0);
    checkOutput("reset_resp", 64'({req_ack, req_err}), 64'h0);
    checkOutput("reset_bus", 64'({adr_o, sel_o, we_o}), 64'h0);
    req_en = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Word read with two wait states
    slave_waits = 2;
    slave_data  = 32'hDEADBEEF;
    applyStimulus(0, 1'b0, 2'd2, 32'h100, 32'h0);
    @(negedge clk);
    checkOutput("t1_cyc", 64'({cyc_o, stb_o}), 64'h3);
    checkOutput("t1_adr", 64'(adr_o), 64'h40);
    checkOutput("t1_sel", 64'(sel_o), 64'hF);
    checkOutput("t1_we", 64'(we_o), 64'h0);
    checkOutput("t1_stl_bus", 64'(req_stl), 64'h1);
    waitResp(30, lat, cyc_cnt);
    checkOutput("t1_lat", 64'(lat + 1), 64'd4);
    checkOutput("t1_cyc_len", 64'(cyc_cnt + 1), 64'd3);
    checkOutput("t1_ack", 64'(req_ack), 64'h1);
    checkOutput("t1_rdata", 64'(req_rdata), 64'hDEADBEEF);
    checkOutput("t1_stl_ack", 64'(req_stl), 64'h0);
    req_en = 2'b00;
    @(negedge clk);
    checkOutput("t1_ack_pulse", 64'(req_ack), 64'h0);
    checkOutput("t1_rdata_hold", 64'(req_rdata), 64'hDEADBEEF);

    // Byte write to the top lane
    slave_waits = 0;
    applyStimulus(1, 1'b1, 2'd0, 32'h103, 32'hA5);
    @(negedge clk);
    checkOutput("t2_sel", 64'(sel_o), 64'h8);
    checkOutput("t2_dat", 64'(dat_o), 64'hA5000000);
    checkOutput("t2_we", 64'(we_o), 64'h1);
    checkOutput("t2_adr", 64'(adr_o), 64'h40);
    checkOutput("t2_stl_bus", 64'(req_stl), 64'h2);
    waitResp(10, lat, cyc_cnt);
    checkOutput("t2_lat", 64'(lat + 1), 64'd2);
    checkOutput("t2_ack", 64'(req_ack), 64'h2);
    checkOutput("t2_stl_ack", 64'(req_stl), 64'h0);
    req_en = 2'b00;
    @(negedge clk);
    checkOutput("t2_ack_pulse", 64'(req_ack), 64'h0);

    // Both ports requesting continuously: alternating grants, one ack per 3 cycles
    slave_data = 32'h12345678;
    applyStimulus(0, 1'b0, 2'd2, 32'h200, 32'h0);
    applyStimulus(1, 1'b0, 2'd2, 32'h300, 32'h0);
    n_acks   = 0;
    last_ack = 0;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      if (req_ack != 2'b00) begin
        if (n_acks < 6) checkOutput("t3_grant", 64'(req_ack), (n_acks % 2 == 0) ? 64'h1 : 64'h2);
        if (n_acks > 0) checkOutput("t3_gap", 64'(i - last_ack), 64'd3);
        else checkOutput("t3_first_lat", 64'(i), 64'd2);
        last_ack = i;
        n_acks++;
      end
    end
    req_en = 2'b00;
    checkOutput("t3_count", 64'(n_acks), 64'd6);
    checkOutput("t3_rdata", 64'(req_rdata), 64'h12345678);
    @(negedge clk);

    // Misaligned halfword: immediate error, no bus cycle
    applyStimulus(0, 1'b0, 2'd1, 32'h101, 32'h0);
    waitResp(10, lat, cyc_cnt);
    checkOutput("t4_lat", 64'(lat), 64'd1);
    checkOutput("t4_cyc", 64'(cyc_cnt), 64'd0);
    checkOutput("t4_err", 64'(req_err), 64'h1);
    checkOutput("t4_ack", 64'(req_ack), 64'h0);
    req_en = 2'b00;
    @(negedge clk);
    checkOutput("t4_err_pulse", 64'(req_err), 64'h0);

    // Silent slave: timeout after 16 strobe cycles
    slave_mode = 1;
    applyStimulus(0, 1'b0, 2'd2, 32'h0, 32'h0);
    waitResp(40, lat, cyc_cnt);
    checkOutput("t5_cyc_len", 64'(cyc_cnt), 64'd16);
    checkOutput("t5_lat", 64'(lat), 64'd17);
    checkOutput("t5_err", 64'(req_err), 64'h1);
    checkOutput("t5_ack", 64'(req_ack), 64'h0);
    req_en = 2'b00;
    @(negedge clk);

    // err_i together with ack_i: error wins
    slave_mode = 2;
    applyStimulus(0, 1'b0, 2'd2, 32'h4, 32'h0);
    waitResp(10, lat, cyc_cnt);
    checkOutput("t5b_err", 64'(req_err), 64'h1);
    checkOutput("t5b_ack", 64'(req_ack), 64'h0);
    checkOutput("t5b_lat", 64'(lat), 64'd2);
    req_en = 2'b00;
    @(negedge clk);

    // Reset during BUS; afterwards round-robin restarts at port 0
    slave_mode = 1;
    applyStimulus(0, 1'b0, 2'd2, 32'h20, 32'h0);
    @(negedge clk);
    checkOutput("t6_cyc_pre", 64'(cyc_o), 64'h1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_cyc_rst", 64'({cyc_o, stb_o}), 64'h0);
    applyStimulus(1, 1'b0, 2'd2, 32'h30, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("t6_no_resp", 64'({req_ack, req_err}), 64'h0);
    checkOutput("t6_stl_rst", 64'(req_stl), 64'h3);
    slave_mode = 0;
    rst = 1'b0;
    waitResp(10, lat, cyc_cnt);
    checkOutput("t6_first_grant", 64'(req_ack), 64'h1);
    checkOutput("t6_lat", 64'(lat), 64'd2);
    req_en = 2'b00;
    @(negedge clk);

    $display("%0d/%0d checks passed", num_passed, num_checks);
    $finish;
  end

endmodule
